button_decoder: RTL
===================

# button_decoder

Debounces and classifies the two active-low Fomu user buttons, which are read through pulled-up SB_IO inputs. It produces a clean level per button plus single-cycle short-press, long-press and (optionally) double-press events. It sits between the button SB_IO instances and downstream LED/control logic such as the SB_RGBA_DRV PWM inputs. It turns raw contact bounce into well-defined user events.

## Interface
- DEBOUNCE_LOG2, 16: input must stay stable for 2**DEBOUNCE_LOG2 cycles before being accepted (≈1.4 ms at 48 MHz)
- LONG_LOG2, 24: press held 2**LONG_LOG2 cycles counts as long press (≈350 ms)
- GAP_LOG2, 23: double-press window after release, 2**GAP_LOG2 cycles (only used with DOUBLE_PRESS_EN)
- clki  input  1  system clock, the only clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- button_n  input  2  raw pad values from SB_IO D_IN_0, 0 = pressed, asynchronous to clki
- pressed  output  2  debounced level, 1 = held
- short_press  output  2  one-cycle pulse per completed short press
- long_press  output  2  one-cycle pulse when a hold reaches the long threshold
- double_press  output  2  one-cycle pulse per double press (tied 0 without DOUBLE_PRESS_EN)

## Operation
- Two identical, independent lanes, one per bit.
- Synchroniser: 2-flop chain on ~button_n gives s2. The chain resets to 0 (released).
- Debouncer:
  - Counter of DEBOUNCE_LOG2 bits.
  - When s2 == stable, the counter clears.
  - When s2 != stable, the counter increments. On the cycle it holds all-ones with a mismatch, stable <= s2 and the counter clears.
  - Any single matching cycle restarts the count.
  - pressed = stable, driven from the register.
- Event FSM per lane. hold_cnt is LONG_LOG2 bits. gap_cnt is GAP_LOG2 bits. Both clear on every state entry and saturate, never wrap.
  - IDLE: stable rises -> DOWN.
  - DOWN: hold_cnt increments each cycle.
    - Reaching all-ones while still pressed -> long_press pulse, go to HELD.
    - stable falls first -> short_press pulse, IDLE. With DOUBLE_PRESS_EN it goes to WAIT instead, with no pulse.
  - HELD: stable falls -> IDLE, no pulse.
  - WAIT (EN only): gap_cnt increments.
    - stable rises -> DOWN2.
    - gap_cnt reaches all-ones -> short_press pulse, IDLE.
    - A rise on the same cycle as expiry: the rise wins and the FSM goes to DOWN2.
  - DOWN2 (EN only): hold_cnt increments.
    - stable falls -> double_press pulse, IDLE.
    - hold_cnt reaches all-ones -> long_press pulse, HELD. The first click is discarded.
- At most one event pulse per lane per cycle. Both lanes may pulse in the same cycle.

## Timing
- Reset: pressed = 0, all pulses = 0, synchroniser = 0, stable = 0, counters = 0, FSM = IDLE. Reset wins over all other activity.
- Press/release latency: pressed changes exactly 2 + 2**DEBOUNCE_LOG2 cycles after button_n changes, for a bounce-free input.
- long_press is asserted in the cycle 2**LONG_LOG2 cycles after pressed rises.
- short_press, without EN, is asserted in the cycle after pressed falls.
- short_press, with EN, is asserted 2**GAP_LOG2 cycles after pressed falls.
- double_press is asserted in the cycle after the second fall of pressed.
- All outputs are registered and pulses are exactly 1 cycle wide.
- Reset while a button is held: the lane starts released. pressed re-rises 2 + 2**DEBOUNCE_LOG2 cycles after rst deasserts and is treated as a new press.

## Configuration
- DOUBLE_PRESS_EN defined: WAIT/DOWN2 states, gap_cnt and double_press are present, and short_press is delayed by the gap window.
- DOUBLE_PRESS_EN undefined: the FSM is IDLE/DOWN/HELD only, short_press fires immediately on release, and double_press is constant 0.

## Test plan
Bench parameters: DEBOUNCE_LOG2=3, LONG_LOG2=6, GAP_LOG2=5.
- Reset: assert rst 3 cycles with button_n=2'b00 -> all outputs 0 during reset. pressed=2'b11 exactly 10 cycles after rst falls.
- Glitch: button_n[0] low for 7 cycles, then bouncing 1/0 every 3 cycles for 40 cycles, then released -> pressed[0] never rises and no pulses.
- Short press, EN off: button_n[0] low 30 cycles -> pressed[0] high 10 cycles after the fall. One short_press[0] pulse in the cycle after pressed[0] falls. long_press stays 0.
- Long press: button_n[1] low 100 cycles -> long_press[1] pulse 64 cycles after pressed[1] rises. No short_press on release.
- Double press, EN on: two 20-cycle presses on lane 0 with a 15-cycle gap -> one double_press[0] after the second release and no short_press. Repeat with a 50-cycle gap -> two short_press[0] pulses, each 32 cycles after its release.
- Simultaneous: both buttons short-pressed with identical timing -> short_press=2'b11 in the same cycle.

Source files
------------

// File: rtl/button_decoder.sv
// Debounces two active-low Fomu buttons and turns them into clean levels plus short/long/double press pulses.
// Latency: pressed follows the pad 2 + 2**DEBOUNCE_LOG2 cycles later; all outputs are registered.
// No backpressure: events are single-cycle pulses that downstream logic must sample. Optional feature macro: DOUBLE_PRESS_EN.
module button_decoder #(
    parameter int DEBOUNCE_LOG2 = 16,
    parameter int LONG_LOG2     = 24,
    parameter int GAP_LOG2      = 23
) (
    input  logic       clki,
    input  logic       rst,
    input  logic [1:0] button_n,
    output logic [1:0] pressed,
    output logic [1:0] short_press,
    output logic [1:0] long_press,
    output logic [1:0] double_press
);

`ifdef DOUBLE_PRESS_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DOWN  = 3'd1,
        ST_HELD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DOWN2 = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;
`endif

    for (genvar l = 0; l < 2; l++) begin : g_lane
        // Synchroniser stages hold the inverted pad, so 1 means pressed.
        logic                     sync1_q;
        logic                     sync2_q;
        // Debouncer: counts consecutive cycles that disagree with the accepted level.
        logic [DEBOUNCE_LOG2-1:0] db_cnt_q;
        logic [DEBOUNCE_LOG2-1:0] db_cnt_d;
        logic                     stable_q;
        logic                     stable_d;
        // Event FSM.
        state_t                   state_q;
        state_t                   state_d;
        logic [LONG_LOG2-1:0]     hold_q;
        logic [LONG_LOG2-1:0]     hold_d;
        logic [LONG_LOG2-1:0]     hold_sat;
        logic                     short_q;
        logic                     short_d;
        logic                     long_q;
        logic                     long_d;
`ifdef DOUBLE_PRESS_EN
        logic [GAP_LOG2-1:0]      gap_q;
        logic [GAP_LOG2-1:0]      gap_d;
        logic [GAP_LOG2-1:0]      gap_sat;
        logic                     dbl_q;
        logic                     dbl_d;
`endif

        // Two-flop synchroniser for the asynchronous pad; resets to released.
        always_ff @(posedge clki) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= ~button_n[l];
                sync2_q <= sync1_q;
            end
        end

        // Accept a new level only after 2**DEBOUNCE_LOG2 consecutive mismatching cycles.
        always_comb begin
            db_cnt_d = '0;
            stable_d = stable_q;
            if (sync2_q != stable_q) begin
                if (&db_cnt_q) begin
                    stable_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Debouncer state register.
        always_ff @(posedge clki) begin
            if (rst) begin
                db_cnt_q <= '0;
                stable_q <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                stable_q <= stable_d;
            end
        end

        // Saturating increments; a count "reaches all-ones" when its next value is all-ones.
        assign hold_sat = (&hold_q) ? hold_q : hold_q + 1'b1;
`ifdef DOUBLE_PRESS_EN
        assign gap_sat  = (&gap_q) ? gap_q : gap_q + 1'b1;
`endif

        // Event FSM next state and pulse decode; counters clear whenever the state changes.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            short_d = 1'b0;
            long_d  = 1'b0;
`ifdef DOUBLE_PRESS_EN
            gap_d   = gap_q;
            dbl_d   = 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (stable_q) begin
                        state_d = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    hold_d = hold_sat;
                    if (!stable_q) begin
`ifdef DOUBLE_PRESS_EN
                        // Hold back the short press until the gap window shows no second click.
                        state_d = ST_WAIT;
`else
                        short_d = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else if (&hold_sat) begin
                        long_d  = 1'b1;
                        state_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!stable_q) begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef DOUBLE_PRESS_EN
                ST_WAIT: begin
                    gap_d = gap_sat;
                    // A second press on the expiry cycle still counts as a double press.
                    if (stable_q) begin
                        state_d = ST_DOWN2;
                    end else if (&gap_sat) begin
                        short_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DOWN2: begin
                    hold_d = hold_sat;
                    if (!stable_q) begin
                        dbl_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (&hold_sat) begin
                        // Second click held long: the first click is dropped.
                        long_d  = 1'b1;
                        state_d = ST_HELD;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (state_d != state_q) begin
                hold_d = '0;
`ifdef DOUBLE_PRESS_EN
                gap_d  = '0;
`endif
            end
        end

        // Event FSM state, counters and registered pulses.
        always_ff @(posedge clki) begin
            if (rst) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
                short_q <= 1'b0;
                long_q  <= 1'b0;
`ifdef DOUBLE_PRESS_EN
                gap_q   <= '0;
                dbl_q   <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                short_q <= short_d;
                long_q  <= long_d;
`ifdef DOUBLE_PRESS_EN
                gap_q   <= gap_d;
                dbl_q   <= dbl_d;
`endif
            end
        end

        assign pressed[l]      = stable_q;
        assign short_press[l]  = short_q;
        assign long_press[l]   = long_q;
`ifdef DOUBLE_PRESS_EN
        assign double_press[l] = dbl_q;
`endif
    end

`ifndef DOUBLE_PRESS_EN
    assign double_press = 2'b00;
`endif

endmodule
